// File: rtl/mips_pkg.sv
// mips_pkg: shared state encodings and defaults for the pipeline debug run controller.
package mips_pkg;
  localparam int STATE_W = 3;
  localparam int DRAIN_CYCLES_DEFAULT = 4;
  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_STEP_WAIT = 3'd2,
    S_STEP_EXEC = 3'd3,
    S_DRAIN     = 3'd4,
    S_DUMP      = 3'd5,
    S_DONE      = 3'd6
  } state_t;
endpackage

// File: rtl/dump_sequencer.sv
// dump_sequencer: register-file dump address counter with valid/ready handshake.
// Ports: clk, rst (sync, active-high); start loads address 0; active marks the dump window
// (valid follows it); ready is the consumer accept; last is the final address;
// addr is the read address; done flags the handshake on the final address.
module dump_sequencer #(
  parameter int NB_ADDR = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               active,
  input  logic               ready,
  input  logic [NB_ADDR-1:0] last,
  output logic [NB_ADDR-1:0] addr,
  output logic               valid,
  output logic               done
);
  assign valid = active;
  assign done  = valid && ready && addr == last;
  always_ff @(posedge clk) begin
    if (rst || start) addr <= '0;
    else if (valid && ready) addr <= addr + NB_ADDR'(1);
  end
endmodule

// File: rtl/pipeline_run_controller.sv
// pipeline_run_controller: free-run / single-step sequencing, HALT drain and register dump.
// Ports: i_clk, i_rst (sync, active-high); i_start/i_step_mode/i_step/i_halt/i_clear control;
// i_rf_data/i_dump_ready dump side; o_pipe_enable/o_pc_freeze drive the pipeline;
// o_dump_addr/o_dump_data/o_dump_valid dump stream; o_cycle_count, o_done, o_state report.
module pipeline_run_controller
  import mips_pkg::*;
#(
  parameter int LEN          = 32,
  parameter int NB_ADDR      = 5,
  parameter int NB_REG       = 32,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_step_mode,
  input  logic               i_step,
  input  logic               i_halt,
  input  logic               i_clear,
  input  logic [LEN-1:0]     i_rf_data,
  input  logic               i_dump_ready,
  output logic               o_pipe_enable,
  output logic               o_pc_freeze,
  output logic [NB_ADDR-1:0] o_dump_addr,
  output logic [LEN-1:0]     o_dump_data,
  output logic               o_dump_valid,
  output logic [LEN-1:0]     o_cycle_count,
  output logic               o_done,
  output logic [STATE_W-1:0] o_state
);
  localparam int NB_DRAIN = $clog2(DRAIN_CYCLES) + 1;
  state_t state, state_nx;
  logic [LEN-1:0] cycle_count;
  logic [NB_DRAIN-1:0] drain;
  logic dump_done;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (i_start) state_nx = i_step_mode ? S_STEP_WAIT : S_RUN;
      S_RUN:       if (i_halt) state_nx = S_DRAIN;
      S_STEP_WAIT: if (i_step) state_nx = S_STEP_EXEC;
      S_STEP_EXEC: state_nx = i_halt ? S_DRAIN : S_STEP_WAIT;
      S_DRAIN:     if (drain == '0) state_nx = S_DUMP;
      S_DUMP:      if (dump_done) state_nx = S_DONE;
      S_DONE:      if (i_clear) state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end
  // drain holds the remaining DRAIN cycles minus one, so DRAIN lasts exactly DRAIN_CYCLES cycles
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      cycle_count <= '0;
      drain       <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE) begin
        if (i_start) begin
          cycle_count <= '0;
          drain       <= '0;
        end
      end else if (o_pipe_enable) cycle_count <= cycle_count + LEN'(1);
      if (state != S_DRAIN && state_nx == S_DRAIN) drain <= NB_DRAIN'(DRAIN_CYCLES - 1);
      else if (state == S_DRAIN && drain != '0) drain <= drain - NB_DRAIN'(1);
    end
  end
  assign o_pipe_enable = state == S_RUN || state == S_STEP_EXEC || state == S_DRAIN;
  assign o_pc_freeze   = state == S_DRAIN || state == S_DUMP || state == S_DONE;
  assign o_done        = state == S_DONE;
  assign o_state       = state;
  assign o_cycle_count = cycle_count;
  assign o_dump_data   = i_rf_data;
  dump_sequencer #(.NB_ADDR(NB_ADDR)) u_dump (
    .clk   (i_clk),
    .rst   (i_rst),
    .start (state == S_DRAIN && drain == '0),
    .active(state == S_DUMP),
    .ready (i_dump_ready),
    .last  (NB_ADDR'(NB_REG - 1)),
    .addr  (o_dump_addr),
    .valid (o_dump_valid),
    .done  (dump_done)
  );
endmodule

// File: tb/tb_pipeline_run_controller.sv
// tb_pipeline_run_controller: randomized bench checking two controller instances against a behavioural model.
module tb_pipeline_run_controller;
  localparam int DR = 4;
  logic clk = 0, rst = 1, start = 0, step_mode = 0, step = 0, halt = 0, clear = 0, ready = 0;
  logic en, frz, valid, done, en4, frz4, valid4, done4;
  logic [4:0] addr, addr4;
  logic [31:0] data, cnt, rf_data, rf_data4;
  logic [3:0] data4, cnt4;
  logic [2:0] st, st4;
  int cmp = 0, err = 0, en_seen = 0;
  int m_st = 0, m_dleft = 0, m_words = 0;
  logic [31:0] m_cnt = 0, ed;
  bit live = 0;
  logic [4:0] q_addr[$];
  logic [31:0] q_data[$];

  function automatic logic [31:0] rf_fn(input logic [4:0] a);
    return 32'hC0DE0000 ^ ({27'd0, a} * 32'h00010203) ^ {27'd0, a};
  endfunction

  assign rf_data  = rf_fn(addr);
  assign rf_data4 = rf_fn(addr4);

  pipeline_run_controller dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_step_mode(step_mode), .i_step(step),
    .i_halt(halt), .i_clear(clear), .i_rf_data(rf_data), .i_dump_ready(ready),
    .o_pipe_enable(en), .o_pc_freeze(frz), .o_dump_addr(addr), .o_dump_data(data),
    .o_dump_valid(valid), .o_cycle_count(cnt), .o_done(done), .o_state(st)
  );

  pipeline_run_controller #(.LEN(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_step_mode(step_mode), .i_step(step),
    .i_halt(halt), .i_clear(clear), .i_rf_data(rf_data4[3:0]), .i_dump_ready(ready),
    .o_pipe_enable(en4), .o_pc_freeze(frz4), .o_dump_addr(addr4), .o_dump_data(data4),
    .o_dump_valid(valid4), .o_cycle_count(cnt4), .o_done(done4), .o_state(st4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    cmp++;
    if (a !== e) begin
      err++;
      $display("FAIL %s t=%0t got %h expected %h", n, $time, a, e);
    end
  endtask

  // model: what each output must be, tracked as phase + remaining drain + words moved
  always @(posedge clk) begin
    if (rst) begin
      m_st = 0; m_cnt = 0; m_dleft = 0; m_words = 0; live = 1;
    end else case (m_st)
      0: if (start) begin m_cnt = 0; m_st = step_mode ? 2 : 1; end
      1: begin m_cnt++; if (halt) begin m_st = 4; m_dleft = DR; end end
      2: if (step) m_st = 3;
      3: begin m_cnt++; if (halt) begin m_st = 4; m_dleft = DR; end else m_st = 2; end
      4: begin m_cnt++; m_dleft--; if (m_dleft == 0) begin m_st = 5; m_words = 0; end end
      5: if (ready) begin m_words++; if (m_words == 32) m_st = 6; end
      6: if (clear) m_st = 0;
      default: m_st = 0;
    endcase
  end

  always @(posedge clk) begin
    if (!rst && en) en_seen++;
    if (!rst && valid && ready) begin
      q_addr.push_back(addr);
      q_data.push_back(data);
    end
  end

  always @(negedge clk) if (live) begin
    ed = rf_fn(5'(m_words % 32));
    chk("state", 32'(st), 32'(m_st));
    chk("enable", 32'(en), 32'(m_st == 1 || m_st == 3 || m_st == 4));
    chk("freeze", 32'(frz), 32'(m_st >= 4 && m_st <= 6));
    chk("valid", 32'(valid), 32'(m_st == 5));
    chk("done", 32'(done), 32'(m_st == 6));
    chk("addr", 32'(addr), 32'(m_words % 32));
    chk("data", data, ed);
    chk("count", cnt, m_cnt);
    chk("len4_state", 32'(st4), 32'(m_st));
    chk("len4_count", 32'(cnt4), 32'(m_cnt[3:0]));
    chk("len4_data", 32'(data4), 32'(ed[3:0]));
    chk("len4_flags", {28'd0, en4, frz4, valid4, done4}, {28'd0, en, frz, valid, done});
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_state(input int s, input int budget);
    int b = 0;
    while (st != s[2:0] && b < budget) begin tick(); b++; end
    if (b >= budget) begin
      cmp++; err++;
      $display("FAIL wait_state_%0d timeout got %0d", s, st);
    end
  endtask

  task automatic run_dump(input bit toggle);
    int b = 0;
    while (st != 3'd6 && b < 500) begin
      ready = toggle ? ~ready : 1'($urandom_range(0, 1));
      tick(); b++;
    end
    ready = 0;
    if (b >= 500) begin
      cmp++; err++;
      $display("FAIL dump_timeout got state %0d expected 6", st);
    end
  endtask

  task automatic check_dump();
    chk("dump_len", 32'(q_addr.size()), 32);
    for (int i = 0; i < q_addr.size() && i < 32; i++) begin
      chk("dump_order", 32'(q_addr[i]), 32'(i));
      chk("dump_word", q_data[i], rf_fn(5'(i)));
    end
    q_addr.delete(); q_data.delete();
  endtask

  initial begin
    repeat (2) tick();
    rst = 0;
    q_addr.delete(); q_data.delete();
    // free run, halt in the 10th run cycle
    en_seen = 0; start = 1; step_mode = 0; tick(); start = 0;
    repeat (9) tick();
    halt = 1; tick(); halt = 0;
    wait_state(5, 20);
    chk("free_count", cnt, 14);
    chk("free_enable_cycles", 32'(en_seen), 14);
    chk("free_first_addr", 32'(addr), 0);
    run_dump(0);
    check_dump();
    chk("done_flag", 32'(done), 1);
    start = 1; tick(); start = 0;
    chk("start_in_done_ignored", 32'(st), 6);
    clear = 1; tick(); clear = 0;
    chk("clear_to_idle", 32'(st), 0);
    // single step, each step held into STEP_EXEC where the repeat is dropped
    en_seen = 0; start = 1; step_mode = 1; tick(); start = 0; step_mode = 0;
    for (int k = 0; k < 3; k++) begin
      repeat (4) tick();
      step = 1; tick(); tick(); step = 0;
    end
    repeat (3) tick();
    chk("step_count", cnt, 3);
    chk("step_enable_cycles", 32'(en_seen), 3);
    step = 1; tick(); step = 0; halt = 1; tick(); halt = 0;
    chk("step_halt_drain", 32'(st), 4);
    chk("step_halt_freeze", 32'(frz), 1);
    wait_state(5, 10);
    chk("step_halt_count", cnt, 8);
    chk("step_halt_enable_cycles", 32'(en_seen), 8);
    // toggling ready, reset once address 12 is presented
    begin
      int b = 0;
      while (addr != 5'd12 && b < 200) begin ready = ~ready; tick(); b++; end
      if (b >= 200) begin cmp++; err++; $display("FAIL reach_addr12 got %0d expected 12", addr); end
    end
    ready = 0; rst = 1; tick();
    chk("rst_state", 32'(st), 0);
    chk("rst_outputs", {27'd0, en, frz, valid, done, 1'b0}, 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_count", cnt, 0);
    rst = 0;
    q_addr.delete(); q_data.delete();
    // 20 enabled cycles: 16 run + 4 drain, 4-bit counter wraps to 4
    en_seen = 0; start = 1; tick(); start = 0;
    repeat (15) tick();
    halt = 1; tick(); halt = 0;
    wait_state(5, 20);
    chk("wrap_count4", 32'(cnt4), 4);
    chk("wrap_count32", cnt, 20);
    run_dump(1);
    check_dump();
    clear = 1; tick(); clear = 0;
    // random traffic, the per-cycle compare follows the model
    for (int i = 0; i < 3000; i++) begin
      rst       = $urandom_range(0, 999) < 3;
      start     = $urandom_range(0, 99) < 10;
      step_mode = 1'($urandom_range(0, 1));
      step      = $urandom_range(0, 99) < 30;
      halt      = $urandom_range(0, 99) < 5;
      clear     = $urandom_range(0, 99) < 20;
      ready     = $urandom_range(0, 99) < 70;
      tick();
    end
    {rst, start, step, halt, clear, ready} = '0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
